qif_synapse: RTL
================

# qif_synapse

Spike-to-current synapse: consumes the `spike_out` train of an upstream QIF neuron and produces the signed 8-bit input current `B` for a downstream `QIFNeuron`. Each accepted spike adds a signed weight to an internal synaptic current. That current decays exponentially toward zero on a prescaled tick. The output is the saturated sum of a constant bias and the synaptic current, so a neuron-synapse-neuron chain can be built from the same primitives.

## Interface
- `BIAS`, default -20: signed 8-bit resting current, added to the synaptic current.
- `TAU_SHIFT`, default 2: decay shift, 1..7.
- `DECAY_PERIOD`, default 4: cycles between decay ticks, at least 1.
- `REFRACT_CYCLES`, default 3: refractory window length, at least 1. Used only with `QIF_SYN_REFRACT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `spike_in` in 1: spike level from the upstream `spike_out`.
- `weight` in 8: signed two's-complement synaptic weight, sampled on an accepted edge.
- `B` out 8: signed current to the downstream neuron, registered.
- `active` out 1: high while the synaptic current `I` is nonzero.
- `spike_count` out 8: count of accepted spikes, wraps.

## Operation
- Internal registers: `I` (signed 8-bit), `spike_q`, prescaler `pc` (width `$clog2(DECAY_PERIOD)`, min 1), FSM state.
- Edge detect: `spike_q <= spike_in` every cycle, including during `rst`. A spike is a rising edge: `spike_in && !spike_q`.
- FSM states:
  - IDLE: `I==0`, `pc` held at 0, `active=0`.
  - ACTIVE: `I!=0`.
- Transitions:
  - IDLE→ACTIVE when an accepted spike makes `I_next!=0`; `pc` restarts at 0.
  - ACTIVE→IDLE when `I_next==0`.
  - Spikes while ACTIVE do not reset `pc`.
- Decay tick: only in ACTIVE, when `pc==DECAY_PERIOD-1`. `pc` then wraps to 0; otherwise `pc` increments.
- Decay step: `s = I >>> TAU_SHIFT` (arithmetic). If `s==0` and `I>0`, then `s=1`. On a tick, `I_dec = I - s`. This guarantees convergence to 0 from either sign.
- Update order on one edge:
  - Apply decay first, then the spike: `I_next = sat8(I_dec + weight)`.
  - Without a tick, `I_dec = I`.
- `sat8` clamps to [-128, 127]. Intermediate sums use 9-bit signed arithmetic.
- Output: `B <= sat8(BIAS + I_next)`. `active <= (I_next != 0)`.
- `spike_count` increments by 1 per accepted spike, 255→0.
- `weight==0` spike: counted; `I` unchanged; the FSM does not leave IDLE.

## Timing
- Reset values: `I=0`, `pc=0`, state IDLE, `B=sat8(BIAS)` (-20 by default), `active=0`, `spike_count=0`.
- Reset mid-operation: every register except `spike_q` is cleared at the next edge, regardless of pending spikes or ticks.
- A `spike_in` level held high through reset release is not an edge.
- Latency: a rising `spike_in` sampled at edge t makes `B`, `active` and `spike_count` reflect the spike after edge t, i.e. in the same cycle the edge is registered.
- Decay cadence: the first tick falls `DECAY_PERIOD` edges after entering ACTIVE, then one tick every `DECAY_PERIOD` edges.
- Back-to-back spikes need `spike_in` to go low for at least 1 cycle between them; the minimum accepted spike period is 2 cycles.

## Configuration
- `QIF_SYN_REFRACT_EN` defined:
  - An accepted spike loads a refractory counter with `REFRACT_CYCLES`.
  - The counter decrements every cycle to 0. Rising edges seen while it is nonzero are ignored: no weight add, no count.
  - Decay continues during refractory.
  - The counter is cleared by `rst`.
- Undefined: no refractory logic; every rising edge is accepted.

## Test plan
All scenarios use the defaults unless stated.
- Single spike, `weight=40`:
  - `B` goes -20→20 one edge after the spike, `active=1`.
  - After 4 more edges, `I=30`, `B=10`.
  - `I` continues decaying to 0; `active` falls and `B` returns to -20.
- Saturation, `weight=100`, spikes every 2 cycles:
  - `I` sequence 100, then 127 (clamped), so `B=107`.
  - With `weight=-128` from IDLE, `B=-128` (clamped).
- Simultaneous tick and spike:
  - With `I=40`, a spike carrying `weight=8` lands on a tick edge.
  - Result is `I=40-10+8=38`, `B=18`.
- Edge detection and reset:
  - `spike_in` held high for 5 cycles → exactly 1 accepted spike, `spike_count=1`.
  - `rst` asserted mid-decay → next edge gives `B=-20`, `active=0`, `spike_count=0`.
  - `spike_in` high across reset release → no spike.
- Negative convergence, `weight=-3`, `TAU_SHIFT=2`:
  - `I` goes -3→-2→-1→0 on successive ticks, then IDLE.
- Refractory, `QIF_SYN_REFRACT_EN` with `REFRACT_CYCLES=3`:
  - Spike edges at t and t+2: the second is ignored, `spike_count=1`.
  - A spike edge at t+4 is accepted, `spike_count=2`.

Source files
------------

// File: rtl/qif_synapse.sv
`default_nettype none
// ============================================================================
//  Module   : qif_synapse
//  Brief    : Spike-to-current synapse. Rising spike edges add a signed weight
//             to an exponentially decaying current; B = sat8(BIAS + I).
//             Optional refractory window enabled by QIF_SYN_REFRACT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_synapse #(
    parameter logic signed [7:0] BIAS           = -8'sd20,
    parameter int                TAU_SHIFT      = 2,
    parameter int                DECAY_PERIOD   = 4,
    parameter int                REFRACT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spike_in,
    input  logic signed [7:0] weight,
    output logic signed [7:0] B,
    output logic              active,
    output logic        [7:0] spike_count
);

    localparam int c_pc_w = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_active = 1'b1;

    function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
        if (v > 9'sd127)
            return 8'sd127;
        else if (v < -9'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

    logic signed [7:0]  r_i;
    logic               r_spike_q;
    logic [c_pc_w-1:0]  r_pc;
    logic [0:0]         r_state;

    logic               w_edge;
    logic               w_accept;
    logic               w_tick;
    logic signed [7:0]  w_shift;
    logic signed [7:0]  w_step;
    logic signed [8:0]  w_i_dec;
    logic signed [8:0]  w_add;
    logic signed [7:0]  w_i_next;
    logic signed [7:0]  w_b_next;
    logic [0:0]         w_state_next;
    logic [c_pc_w-1:0]  w_pc_next;

    assign w_edge = spike_in && !r_spike_q;

`ifdef QIF_SYN_REFRACT_EN
    localparam int c_ref_w = $clog2(REFRACT_CYCLES + 1);

    logic [c_ref_w-1:0] r_refract;

    assign w_accept = w_edge && (r_refract == '0);

    always_ff @(posedge clk) begin
        if (rst)
            r_refract <= '0;
        else if (w_accept)
            r_refract <= c_ref_w'(REFRACT_CYCLES);
        else if (r_refract != '0)
            r_refract <= r_refract - 1'b1;
    end
`else
    assign w_accept = w_edge;
`endif

    always_comb begin
        w_tick  = (r_state == c_st_active) && (r_pc == c_pc_w'(DECAY_PERIOD - 1));
        w_shift = r_i >>> TAU_SHIFT;
        // A small positive current would otherwise stall at floor(I/2^k)=0.
        w_step  = ((w_shift == 8'sd0) && (r_i > 8'sd0)) ? 8'sd1 : w_shift;
        w_i_dec = w_tick ? ({r_i[7], r_i} - {w_step[7], w_step}) : {r_i[7], r_i};
        w_add   = w_accept ? {weight[7], weight} : 9'sd0;
        w_i_next = sat8(w_i_dec + w_add);
        w_b_next = sat8({BIAS[7], BIAS} + {w_i_next[7], w_i_next});

        w_state_next = (w_i_next != 8'sd0) ? c_st_active : c_st_idle;

        if ((r_state == c_st_idle) || (w_state_next == c_st_idle) || w_tick)
            w_pc_next = '0;
        else
            w_pc_next = r_pc + 1'b1;
    end

    // Edge history keeps tracking through reset so a held level is not a spike.
    always_ff @(posedge clk) begin
        r_spike_q <= spike_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i         <= 8'sd0;
            r_pc        <= '0;
            r_state     <= c_st_idle;
            B           <= BIAS;
            active      <= 1'b0;
            spike_count <= 8'd0;
        end else begin
            r_i         <= w_i_next;
            r_pc        <= w_pc_next;
            r_state     <= w_state_next;
            B           <= w_b_next;
            active      <= (w_i_next != 8'sd0);
            spike_count <= spike_count + {7'd0, w_accept};
        end
    end

endmodule
`default_nettype wire
